// File: rtl/io_responder_if.sv
// CPU-side IN/OUT handshake bundle between the CPU and io_responder.
// The master modport is the CPU and the slave modport is the peripheral.
interface io_responder_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  io_req;
    logic [1:0]            io_ctrl;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  io_busy;
    logic                  io_done;

    modport master (
        output io_req,
        output io_ctrl,
        output wr_data,
        input  rd_data,
        input  io_busy,
        input  io_done
    );

    modport slave (
        input  io_req,
        input  io_ctrl,
        input  wr_data,
        output rd_data,
        output io_busy,
        output io_done
    );
endinterface

// File: rtl/io_responder.sv
// Peripheral end of the CPU IN/OUT port: IN waits for a button press and returns the switches,
// OUT converts the value to BCD digits. Define IO_DEBOUNCE_EN to debounce the button.
module io_responder #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned SW_WIDTH        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset,
    io_responder_if.slave       bus,
    input  logic [SW_WIDTH-1:0] sw_in,
    input  logic                button,
    output logic [3:0]          unidade,
    output logic [3:0]          dezena,
    output logic [3:0]          centena,
    output logic                ovf
);

    if (SW_WIDTH > 10 || SW_WIDTH > DATA_WIDTH || DATA_WIDTH < 10 || DEBOUNCE_CYCLES == 0)
    begin : gBadParams
        $error("io_responder: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        Idle,
        WaitBtn,
        Convert,
        Done
    } stateT;

    localparam logic [1:0] CtrlIn  = 2'b01;
    localparam logic [1:0] CtrlOut = 2'b10;

    stateT                 stateQ, stateD;
    logic [9:0]            binQ, binD;
    logic [10:0]           bcdQ, bcdD;
    logic [3:0]            bitCntQ, bitCntD;
    logic [11:0]           digitsQ, digitsD;
    logic [DATA_WIDTH-1:0] rdDataQ, rdDataD;
    logic                  ovfQ, ovfD;

    logic                  btnMeta, btnSync, btnLevel, btnPrev, btnRise;
    logic                  overRange;
    logic [9:0]            satVal;
    logic [11:0]           bcdShift;

    // ---------------------------------------------------------------- button path
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btnMeta <= 1'b0;
            btnSync <= 1'b0;
        end else begin
            btnMeta <= button;
            btnSync <= btnMeta;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int unsigned DebWidth = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DebWidth-1:0] debCnt;
    logic                btnDeb;

    // The new level must survive a full count while still differing before it is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            debCnt <= '0;
            btnDeb <= 1'b0;
        end else if (btnSync != btnDeb) begin
            if (debCnt == DebWidth'(DEBOUNCE_CYCLES)) begin
                btnDeb <= btnSync;
                debCnt <= '0;
            end else begin
                debCnt <= debCnt + 1'b1;
            end
        end else begin
            debCnt <= '0;
        end
    end

    assign btnLevel = btnDeb;
`else
    assign btnLevel = btnSync;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btnPrev <= 1'b0;
        end else begin
            btnPrev <= btnLevel;
        end
    end

    assign btnRise = btnLevel & ~btnPrev;

    // ---------------------------------------------------------------- double dabble step
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Hundreds never exceeds 4 before the final shift, so it needs neither adjust nor a 4th bit.
    assign bcdShift  = {bcdQ[10:8], add3(bcdQ[7:4]), add3(bcdQ[3:0]), binQ[9]};
    assign overRange = bus.wr_data > DATA_WIDTH'(999);
    assign satVal    = overRange ? 10'd999 : bus.wr_data[9:0];

    // ---------------------------------------------------------------- FSM
    always_comb begin
        stateD  = stateQ;
        binD    = binQ;
        bcdD    = bcdQ;
        bitCntD = bitCntQ;
        digitsD = digitsQ;
        rdDataD = rdDataQ;
        ovfD    = ovfQ;

        unique case (stateQ)
            Idle: begin
                if (bus.io_req) begin
                    if (bus.io_ctrl == CtrlIn) begin
                        stateD = WaitBtn;
                    end else if (bus.io_ctrl == CtrlOut) begin
                        binD    = satVal;
                        bcdD    = '0;
                        bitCntD = '0;
                        ovfD    = overRange;
                        stateD  = Convert;
                    end else begin
                        stateD = Done;
                    end
                end
            end
            WaitBtn: begin
                if (btnRise) begin
                    rdDataD = DATA_WIDTH'(sw_in);
                    stateD  = Done;
                end
            end
            Convert: begin
                binD    = {binQ[8:0], 1'b0};
                bcdD    = bcdShift[10:0];
                bitCntD = bitCntQ + 4'd1;
                if (bitCntQ == 4'd9) begin
                    digitsD = bcdShift;
                    stateD  = Done;
                end
            end
            Done: begin
                stateD = Idle;
            end
            default: begin
                stateD = Idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ  <= Idle;
            binQ    <= '0;
            bcdQ    <= '0;
            bitCntQ <= '0;
            digitsQ <= '0;
            rdDataQ <= '0;
            ovfQ    <= 1'b0;
        end else begin
            stateQ  <= stateD;
            binQ    <= binD;
            bcdQ    <= bcdD;
            bitCntQ <= bitCntD;
            digitsQ <= digitsD;
            rdDataQ <= rdDataD;
            ovfQ    <= ovfD;
        end
    end

    assign bus.rd_data = rdDataQ;
    assign bus.io_busy = (stateQ != Idle);
    assign bus.io_done = (stateQ == Done);
    assign centena     = digitsQ[11:8];
    assign dezena      = digitsQ[7:4];
    assign unidade     = digitsQ[3:0];
    assign ovf         = ovfQ;

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder: stimulus queues expected completions, a monitor checks them.
// Build with IO_DEBOUNCE_EN defined to also exercise the debounce filter.
module tb_io_responder;

    localparam int unsigned DW = 32;
`ifdef IO_DEBOUNCE_EN
    localparam int PressLat = 12;
`else
    localparam int PressLat = 3;
`endif

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] rd;
        logic [3:0]  c;
        logic [3:0]  d;
        logic [3:0]  u;
        logic        ov;
    } expT;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] swIn;
    logic       button;
    logic [3:0] unidade, dezena, centena;
    logic       ovf;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    expT         sbQ[$];
    expT         e;
    logic [31:0] expRd = '0;
    logic [3:0]  expC = '0, expD = '0, expU = '0;
    logic        expOv = 1'b0;

    io_responder_if #(.DATA_WIDTH(DW)) bus ();

    io_responder #(
        .DATA_WIDTH(DW),
        .SW_WIDTH(4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .sw_in(swIn),
        .button(button),
        .unidade(unidade),
        .dezena(dezena),
        .centena(centena),
        .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every io_done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && bus.io_done === 1'b1) begin
            if (sbQ.size() == 0) begin
                check("spurious io_done", 32'(bus.io_done), 32'd0);
            end else begin
                e = sbQ.pop_front();
                check({e.name, " latency"}, 32'(cyc), 32'(e.cyc));
                check({e.name, " rd_data"}, bus.rd_data, e.rd);
                check({e.name, " centena"}, 32'(centena), 32'(e.c));
                check({e.name, " dezena"}, 32'(dezena), 32'(e.d));
                check({e.name, " unidade"}, 32'(unidade), 32'(e.u));
                check({e.name, " ovf"}, 32'(ovf), 32'(e.ov));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input string name, input int doneCyc);
        sbQ.push_back('{name: name, cyc: doneCyc, rd: expRd, c: expC, d: expD, u: expU,
                        ov: expOv});
    endtask

    task automatic issue(input logic [1:0] ctrl, input logic [31:0] data);
        bus.io_req  = 1'b1;
        bus.io_ctrl = ctrl;
        bus.wr_data = data;
        tick();
        bus.io_req  = 1'b0;
        bus.io_ctrl = 2'b00;
        bus.wr_data = '0;
    endtask

    task automatic waitDone(input string name);
        int k = 0;
        while (bus.io_done !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        check({name, " done seen"}, 32'(bus.io_done), 32'd1);
    endtask

    // Issue an OUT (or no-op), wait for completion, then step into the following IDLE cycle.
    task automatic doOp(input string name, input logic [1:0] ctrl, input logic [31:0] data,
                        input int lat, input logic [3:0] c, input logic [3:0] d,
                        input logic [3:0] u, input logic ov);
        expC  = c;
        expD  = d;
        expU  = u;
        expOv = ov;
        pushExp(name, cyc + lat);
        issue(ctrl, data);
        waitDone(name);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        bus.io_req  = 1'b0;
        bus.io_ctrl = 2'b00;
        bus.wr_data = '0;
        swIn        = 4'h0;
        button      = 1'b0;
        repeat (3) tick();
        check("reset rd_data", bus.rd_data, 32'd0);
        check("reset io_busy", 32'(bus.io_busy), 32'd0);
        check("reset io_done", 32'(bus.io_done), 32'd0);
        check("reset digits", {20'd0, centena, dezena, unidade}, 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // OUT 473, with digits held at their old values during conversion
        expC = 4'd4; expD = 4'd7; expU = 4'd3; expOv = 1'b0;
        pushExp("out473", cyc + 11);
        issue(2'b10, 32'd473);
        check("out473 busy", 32'(bus.io_busy), 32'd1);
        repeat (4) tick();
        check("out473 digits held", {20'd0, centena, dezena, unidade}, 32'd0);
        waitDone("out473");
        tick();
        check("out473 idle after", 32'(bus.io_busy), 32'd0);

        // Reset mid-conversion aborts without a completion
        issue(2'b10, 32'd123);
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        check("abort io_busy", 32'(bus.io_busy), 32'd0);
        check("abort digits", {20'd0, centena, dezena, unidade}, 32'd0);
        expC = '0; expD = '0; expU = '0; expOv = 1'b0; expRd = '0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (15) tick();
        check("abort stays idle", 32'(bus.io_busy), 32'd0);

        // Saturation, boundaries and back-to-back requests
        doOp("out1500", 2'b10, 32'd1500, 11, 4'd9, 4'd9, 4'd9, 1'b1);
        doOp("out0", 2'b10, 32'd0, 11, 4'd0, 4'd0, 4'd0, 1'b0);
        doOp("out999", 2'b10, 32'd999, 11, 4'd9, 4'd9, 4'd9, 1'b0);
        doOp("out1000", 2'b10, 32'd1000, 11, 4'd9, 4'd9, 4'd9, 1'b1);
        doOp("outHigh", 2'b10, 32'h1000_0005, 11, 4'd9, 4'd9, 4'd9, 1'b1);
        doOp("out305", 2'b10, 32'd305, 11, 4'd3, 4'd0, 4'd5, 1'b0);
        doOp("nop00", 2'b00, 32'd77, 1, 4'd3, 4'd0, 4'd5, 1'b0);
        doOp("nop11", 2'b11, 32'd88, 1, 4'd3, 4'd0, 4'd5, 1'b0);

        // IN with the button already held: a fresh press is required
        swIn   = 4'hA;
        button = 1'b1;
        repeat (20) tick();
        issue(2'b01, 32'd0);
        repeat (15) tick();
        check("in held busy", 32'(bus.io_busy), 32'd1);
        button = 1'b0;
        repeat (15) tick();
        check("in released busy", 32'(bus.io_busy), 32'd1);
        expRd = 32'h0000_000A;
        pushExp("inA", cyc + PressLat);
        button = 1'b1;
        waitDone("inA");
        tick();
        button = 1'b0;
        swIn   = 4'h5;
        repeat (3) tick();
        check("in rd_data holds", bus.rd_data, 32'h0000_000A);

        // IN request during CONVERT is dropped
        expC = 4'd0; expD = 4'd4; expU = 4'd2; expOv = 1'b0;
        pushExp("out42", cyc + 11);
        issue(2'b10, 32'd42);
        tick();
        issue(2'b01, 32'd0);
        waitDone("out42");
        tick();
        check("out42 idle after", 32'(bus.io_busy), 32'd0);
        repeat (5) tick();
        check("ignored IN not started", 32'(bus.io_busy), 32'd0);

`ifdef IO_DEBOUNCE_EN
        // Short glitch is filtered, a long pulse is accepted
        repeat (15) tick();
        issue(2'b01, 32'd0);
        repeat (2) tick();
        button = 1'b1;
        repeat (5) tick();
        button = 1'b0;
        repeat (25) tick();
        check("deb glitch busy", 32'(bus.io_busy), 32'd1);
        expRd = 32'h0000_0005;
        pushExp("deb12", cyc + 12);
        button = 1'b1;
        repeat (12) tick();
        button = 1'b0;
        waitDone("deb12");
        tick();
`endif

        repeat (5) tick();
        check("scoreboard drained", 32'(sbQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
